// File: rtl/msg_arbiter_pkg.sv
// rtl/msg_arbiter_pkg.sv - shared types and constants for the uplink message arbiter
package msg_arbiter_pkg;

    // Frame sequencer states; CSUM is only reachable when MSG_ARB_CHECKSUM_EN is defined
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_ID      = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CSUM    = 3'd5
    } state_t;

    localparam logic [7:0] START_BYTE_DEF = 8'h55;
    localparam int         MAX_N_SRC      = 8;
    localparam int         GID_W          = 3;

endpackage

// File: rtl/msg_arbiter_rr_picker.sv
// rtl/msg_arbiter_rr_picker.sv - combinational round-robin first-requester search
//   req        : request vector, one bit per source
//   last_grant : index granted most recently; search starts one above it
//   idx        : first requester found scanning upward with wrap
//   any_req    : at least one request present
module msg_arbiter_rr_picker
    import msg_arbiter_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [GID_W-1:0] last_grant,
    output logic [GID_W-1:0] idx,
    output logic             any_req
);

    logic [3:0] cand;

    // Scan from the farthest candidate down to the nearest so the nearest
    // requester above last_grant is the one left in idx.
    always_comb begin
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            cand = 4'((int'(last_grant) + k) % N_SRC);
            if (|(req & (N_SRC'(1) << cand))) begin
                idx     = cand[GID_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msg_arbiter.sv
// rtl/msg_arbiter.sv - round-robin framer sharing the uplink byte transmitter between sources
//   Optional checksum byte enabled by defining MSG_ARB_CHECKSUM_EN.
//   clk, n_rst            : clock, asynchronous active-low reset
//   src_have_msg/len/data : per-source message presence, length and current payload byte
//   src_rdreq             : per-source one-cycle pop strobe
//   tx_data/valid/ready   : frame byte stream to the serializer
//   busy, grant_id        : frame in progress, owner of the current frame
//   frame_done            : pulse on transfer of the last frame byte
module msg_arbiter
    import msg_arbiter_pkg::*;
#(
    parameter int         N_SRC      = 4,
    parameter logic [7:0] START_BYTE = START_BYTE_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [N_SRC-1:0]     src_have_msg,
    input  logic [8*N_SRC-1:0]   src_len,
    input  logic [8*N_SRC-1:0]   src_data,
    output logic [N_SRC-1:0]     src_rdreq,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [GID_W-1:0]     grant_id,
    output logic                 frame_done
);

`ifdef MSG_ARB_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    state_t           state, state_n;
    logic [GID_W-1:0] last_grant;
    logic [GID_W-1:0] pick_idx;
    logic             pick_any;
    logic [7:0]       len_q;
    logic [7:0]       byte_cnt;
    logic             rdreq_en;
    logic             xfer;
    logic [7:0]       payload_byte;

    msg_arbiter_rr_picker #(.N_SRC(N_SRC)) u_picker (
        .req        (src_have_msg),
        .last_grant (last_grant),
        .idx        (pick_idx),
        .any_req    (pick_any)
    );

    assign xfer         = tx_valid & tx_ready;
    assign payload_byte = 8'(src_data >> {grant_id, 3'b000});
    assign busy         = (state != ST_IDLE);
    assign src_rdreq    = rdreq_en ? (N_SRC'(1) << grant_id) : '0;

`ifdef MSG_ARB_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            csum_q <= '0;
        end else if (state == ST_IDLE) begin
            csum_q <= '0;
        end else if (xfer && (state == ST_ID || state == ST_LEN || state == ST_PAYLOAD)) begin
            csum_q <= csum_q ^ tx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            last_grant <= GID_W'(N_SRC - 1);
            grant_id   <= '0;
            len_q      <= '0;
            byte_cnt   <= '0;
        end else begin
            state <= state_n;
            // Length and owner are frozen at grant; later source changes are ignored.
            if (state == ST_IDLE && pick_any) begin
                grant_id   <= pick_idx;
                last_grant <= pick_idx;
                len_q      <= 8'(src_len >> {pick_idx, 3'b000});
            end
            if (state == ST_LEN && xfer) begin
                byte_cnt <= len_q;
            end else if (state == ST_PAYLOAD && xfer) begin
                byte_cnt <= byte_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        rdreq_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) state_n = ST_START;
            end
            ST_START: begin
                tx_valid = 1'b1;
                tx_data  = START_BYTE;
                if (xfer) state_n = ST_ID;
            end
            ST_ID: begin
                tx_valid = 1'b1;
                tx_data  = 8'(grant_id);
                if (xfer) state_n = ST_LEN;
            end
            ST_LEN: begin
                tx_valid = 1'b1;
                tx_data  = len_q;
                if (xfer) begin
                    if (len_q != 8'd0) begin
                        state_n = ST_PAYLOAD;
                    end else begin
                        // Empty message: one pop still releases the source.
                        rdreq_en = 1'b1;
                        if (CSUM_EN) begin
                            state_n = ST_CSUM;
                        end else begin
                            state_n    = ST_IDLE;
                            frame_done = 1'b1;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = payload_byte;
                rdreq_en = tx_ready;
                if (xfer && byte_cnt == 8'd1) begin
                    if (CSUM_EN) begin
                        state_n = ST_CSUM;
                    end else begin
                        state_n    = ST_IDLE;
                        frame_done = 1'b1;
                    end
                end
            end
`ifdef MSG_ARB_CHECKSUM_EN
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (xfer) begin
                    state_n    = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: doc/msg_arbiter.md
# msg_arbiter

Shares the single uplink byte transmitter between N message sources, each presenting the common source interface (have_msg, len, data_out, rdreq). Selects a requesting source with round-robin priority, frames its message as start byte, source ID, length, payload and optional checksum, and pops payload bytes from the source one rdreq pulse per byte. Sits between the message sources (keep-alive responder, status and readback sources) and the uplink serializer.

## Interface
- N_SRC, 4, number of message sources; 2..8
- START_BYTE, 8'h55, first byte of every frame
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- src_have_msg  in  N_SRC  source i holds a complete message
- src_len  in  8*N_SRC  payload length of source i, bits [8i+7:8i]
- src_data  in  8*N_SRC  current payload byte of source i
- src_rdreq  out  N_SRC  one-cycle pop strobe, at most one bit high
- tx_data  out  8  frame byte to serializer
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serializer accepts byte; transfer = tx_valid & tx_ready
- busy  out  1  frame in progress (state != IDLE)
- grant_id  out  3  index of source owning current frame
- frame_done  out  1  one-cycle pulse on transfer of last frame byte

## Operation
- States: IDLE, START, ID, LEN, PAYLOAD, CSUM.
- IDLE: if any src_have_msg, pick first requester scanning from (last_grant+1) mod N_SRC upward with wrap; latch grant_id, latch len_q = src_len[grant]; next state START. No request: stay.
- tx_data by state: START -> START_BYTE; ID -> {5'b0, grant_id}; LEN -> len_q; PAYLOAD -> src_data[grant] (combinational pass-through); CSUM -> csum_q. tx_valid = 1 in all states except IDLE.
- Each state advances only on transfer; tx_valid never drops and tx_data never changes while waiting on tx_ready.
- LEN transfer: len_q != 0 -> PAYLOAD, byte_cnt = len_q. len_q == 0 -> single src_rdreq[grant] pulse in this transfer cycle (releases source), then CSUM or IDLE.
- PAYLOAD: src_rdreq[grant] = tx_ready (i.e. every transfer pops one byte); byte_cnt decrements; transfer with byte_cnt == 1 -> CSUM or IDLE.
- src_len and src_have_msg changes after grant are ignored until return to IDLE.
- last_grant updated at grant; frame_done pulses on final transfer; next arbitration occurs in IDLE the following cycle (one idle cycle between frames).
- Reset values: state IDLE, all src_rdreq 0, tx_valid 0, tx_data 8'h00, busy 0, grant_id 0, frame_done 0, byte_cnt 0, last_grant N_SRC-1 (source 0 wins first).
- Reset mid-frame aborts frame immediately; no further rdreq; partial frame is discarded by downstream framing.

## Timing
- Request sampled in IDLE at cycle t -> tx_valid high with START_BYTE at t+1.
- Minimum frame length 3 + len (+1 with checksum) transfer cycles; with tx_ready tied high, frame occupies exactly that many cycles plus one IDLE cycle.
- src_data must be valid combinationally while source's have_msg is high; source advances to next byte on the clock edge where rdreq is high.

## Configuration
- MSG_ARB_CHECKSUM_EN defined: CSUM state present; csum_q = XOR of ID byte, LEN byte and all payload bytes (START excluded), cleared at grant, accumulated on each transfer; frame_done on CSUM transfer.
- Undefined: no CSUM state or csum_q register; frame ends after last payload byte (or LEN byte when len 0).

## Structure
- Shared package: state enum, START_BYTE default, max N_SRC constant, grant-ID width.
- One sub-module: rr_picker (combinational round-robin first-requester search from last_grant+1, outputs index and any_req).

## Test plan
- Source 2 only, len 1, data EA, tx_ready high -> bytes 55, 02, 01, EA, (CSUM E9); one rdreq[2] pulse aligned with EA transfer.
- Sources 0 and 1 request continuously from reset -> grants 0,1,0,1; never same source twice while other waits.
- tx_ready held low 5 cycles during PAYLOAD -> tx_data/tx_valid stable, no rdreq until ready rises, byte count unaffected.
- len 0 on source 3 -> bytes 55, 03, 00, (CSUM 03); exactly one rdreq[3] on LEN transfer.
- src_len changed from 4 to 9 after grant -> exactly 4 payload bytes and 4 rdreq pulses.
- n_rst asserted mid-PAYLOAD -> tx_valid, rdreq, busy 0 immediately; after release first grant goes to source 0.
